// File: rtl/plot_fb_writer.sv
// Plot-stream sink: buffers (x, y, colour) plots in a FIFO and writes them to a
// single-port frame-buffer RAM, sharing the port with scan-out reads and a clear engine.
module plot_fb_writer #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  iX,
    input  logic [6:0]  iY,
    input  logic [8:0]  iColour,
    input  logic        iPlot,
    input  logic        iClear,
    input  logic [8:0]  iClearColour,
    input  logic        iClrFlags,
    input  logic        iRdReq,
    input  logic [14:0] iRdAddr,
    output logic        oRdValid,
    output logic [8:0]  oRdData,
    output logic [14:0] fb_address,
    output logic [8:0]  fb_data,
    output logic        fb_wren,
    input  logic [8:0]  fb_q,
    output logic        oBusy,
    output logic        oClearDone,
    output logic        oOverflow,
    output logic [7:0]  oDropCount
);
    localparam int unsigned AW = 15;
    localparam int unsigned CW = 9;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;
    localparam logic [7:0]    WIDTH_L   = 8'(WIDTH);
    localparam logic [6:0]    HEIGHT_L  = 7'(HEIGHT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] colour;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [CW-1:0] clr_col_q, clr_col_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [AW-1:0] fb_address_q, fb_address_d;
    logic [CW-1:0] fb_data_q, fb_data_d;
    logic          fb_wren_q, fb_wren_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_valid_q, rd_valid_d;
    logic          busy_q, busy_d;
    logic          clear_done_q, clear_done_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    entry_t        push_entry_d;
    entry_t        fifo_mem_q [FIFO_DEPTH];

    logic in_range, fifo_full, fifo_empty;
    logic grant_rd, grant_clr, grant_pop, push;

    // Port arbitration, FIFO bookkeeping, clear FSM and status flags
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_col_d    = clr_col_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fb_address_d = '0;
        fb_data_d    = '0;
        fb_wren_d    = 1'b0;
        clear_done_d = 1'b0;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;

        // y*160 + x without a multiplier
        push_entry_d.addr   = (AW'(iY) << 7) + (AW'(iY) << 5) + AW'(iX);
        push_entry_d.colour = iColour;

        in_range   = (iX < WIDTH_L) && (iY < HEIGHT_L);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);

        grant_rd  = iRdReq;
        grant_clr = !iRdReq && (state_q == S_CLEAR);
        grant_pop = !iRdReq && (state_q == S_IDLE) && !fifo_empty;
        push      = iPlot && in_range && (!fifo_full || grant_pop);

        rd_pend_d  = grant_rd;
        rd_valid_d = rd_pend_q;

        if (grant_rd) begin
            fb_address_d = iRdAddr;
        end else if (grant_clr) begin
            fb_address_d = clr_cnt_q;
            fb_data_d    = clr_col_q;
            fb_wren_d    = 1'b1;
        end else if (grant_pop) begin
            fb_address_d = fifo_mem_q[rd_ptr_q].addr;
            fb_data_d    = fifo_mem_q[rd_ptr_q].colour;
            fb_wren_d    = 1'b1;
            rd_ptr_d     = rd_ptr_q + PW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + NW'(push) - NW'(grant_pop);

        case (state_q)
            S_IDLE: begin
                if (iClear) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    clr_col_d = iClearColour;
                end
            end
            S_CLEAR: begin
                if (grant_clr) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d      = S_DONE;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + AW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Flag clear wins over any same-cycle overflow or drop
        if (iClrFlags) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (iPlot && in_range && fifo_full && !grant_pop) begin
                overflow_d = 1'b1;
            end
            if (iPlot && !in_range && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            clr_col_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fb_address_q <= '0;
            fb_data_q    <= '0;
            fb_wren_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_col_q    <= clr_col_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fb_address_q <= fb_address_d;
            fb_data_q    <= fb_data_d;
            fb_wren_q    <= fb_wren_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_entry_d;
        end
    end

    assign fb_address = fb_address_q;
    assign fb_data    = fb_data_q;
    assign fb_wren    = fb_wren_q;
    assign oRdValid   = rd_valid_q;
    assign oRdData    = rd_valid_q ? fb_q : '0;
    assign oBusy      = busy_q;
    assign oClearDone = clear_done_q;
    assign oOverflow  = overflow_q;
    assign oDropCount = drop_cnt_q;

endmodule

// File: tb/tb_plot_fb_writer.sv
// Bench for plot_fb_writer: frame-buffer RAM model, queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_plot_fb_writer;
    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [8:0]  iColour;
    logic        iPlot;
    logic        iClear;
    logic [8:0]  iClearColour;
    logic        iClrFlags;
    logic        iRdReq;
    logic [14:0] iRdAddr;
    logic        oRdValid;
    logic [8:0]  oRdData;
    logic [14:0] fb_address;
    logic [8:0]  fb_data;
    logic        fb_wren;
    logic [8:0]  fb_q;
    logic        oBusy;
    logic        oClearDone;
    logic        oOverflow;
    logic [7:0]  oDropCount;

    plot_fb_writer dut (
        .clock(clock), .resetn(resetn), .iX(iX), .iY(iY), .iColour(iColour),
        .iPlot(iPlot), .iClear(iClear), .iClearColour(iClearColour),
        .iClrFlags(iClrFlags), .iRdReq(iRdReq), .iRdAddr(iRdAddr),
        .oRdValid(oRdValid), .oRdData(oRdData), .fb_address(fb_address),
        .fb_data(fb_data), .fb_wren(fb_wren), .fb_q(fb_q), .oBusy(oBusy),
        .oClearDone(oClearDone), .oOverflow(oOverflow), .oDropCount(oDropCount)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM, read-before-write
    logic [8:0] ram [0:32767];
    always @(posedge clock) begin
        if (fb_wren) ram[fb_address] <= fb_data;
        fb_q <= ram[fb_address];
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [14:0] a;
        logic [8:0]  c;
    } ent_t;

    ent_t       mq[$];
    ent_t       ment;
    logic [8:0] img [0:32767];
    bit         img_vld [0:32767];
    int         mode;       // 0 normal, 1 clearing, 2 clear just finished
    int         clr_idx;
    logic [8:0] clr_col;
    int         sz0;
    bit         g_rd, g_clr, g_pop, inr;
    bit         rv1, rk1;
    logic [8:0] rd1;
    bit         e_wren, e_achk, e_rv, e_rk, e_busy, e_done, e_ovf;
    logic [14:0] e_addr;
    logic [8:0]  e_data, e_rdata;
    int          e_drop;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            mode = 0; clr_idx = 0; clr_col = '0;
            rv1 = 0; rk1 = 0; rd1 = '0;
            e_wren = 0; e_achk = 0; e_addr = '0; e_data = '0;
            e_rv = 0; e_rk = 0; e_rdata = '0;
            e_busy = 0; e_done = 0; e_ovf = 0; e_drop = 0;
        end else begin
            sz0   = mq.size();
            g_rd  = iRdReq;
            g_clr = !g_rd && (mode == 1);
            g_pop = !g_rd && (mode == 0) && (sz0 != 0);
            e_rv = rv1; e_rk = rk1; e_rdata = rd1;
            rv1 = g_rd; rk1 = g_rd && img_vld[iRdAddr]; rd1 = img[iRdAddr];
            e_wren = 0; e_achk = 0;
            if (g_rd) begin
                e_achk = 1; e_addr = iRdAddr;
            end else if (g_clr) begin
                e_achk = 1; e_wren = 1; e_addr = 15'(clr_idx); e_data = clr_col;
                img[clr_idx] = clr_col; img_vld[clr_idx] = 1;
            end else if (g_pop) begin
                ment = mq.pop_front();
                e_achk = 1; e_wren = 1; e_addr = ment.a; e_data = ment.c;
                img[ment.a] = ment.c; img_vld[ment.a] = 1;
            end
            inr = (int'(iX) < 160) && (int'(iY) < 120);
            if (iPlot && inr && (sz0 < 8 || g_pop))
                mq.push_back('{a: 15'(int'(iY) * 160 + int'(iX)), c: iColour});
            if (iClrFlags) begin
                e_ovf = 0; e_drop = 0;
            end else begin
                if (iPlot && inr && sz0 == 8 && !g_pop) e_ovf = 1;
                if (iPlot && !inr && e_drop < 255) e_drop++;
            end
            e_done = 0;
            if (mode == 0) begin
                if (iClear) begin mode = 1; clr_idx = 0; clr_col = iClearColour; end
            end else if (mode == 1) begin
                if (g_clr) begin
                    if (clr_idx == 19199) begin mode = 2; e_done = 1; end
                    else clr_idx++;
                end
            end else begin
                mode = 0;
            end
            e_busy = (mq.size() != 0) || (mode != 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("fb_wren", 32'(fb_wren), 32'(e_wren));
            if (e_achk) chk("fb_address", 32'(fb_address), 32'(e_addr));
            if (e_wren) chk("fb_data", 32'(fb_data), 32'(e_data));
            chk("oRdValid", 32'(oRdValid), 32'(e_rv));
            if (e_rv && e_rk) chk("oRdData", 32'(oRdData), 32'(e_rdata));
            chk("oBusy", 32'(oBusy), 32'(e_busy));
            chk("oClearDone", 32'(oClearDone), 32'(e_done));
            chk("oOverflow", 32'(oOverflow), 32'(e_ovf));
            chk("oDropCount", 32'(oDropCount), 32'(e_drop));
        end
    end

    // ---------------- stimulus ----------------
    logic [14:0] wa[$];
    logic [8:0]  wd[$];
    int          cnt, ndone, rd_pct;

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (fb_wren) begin wa.push_back(fb_address); wd.push_back(fb_data); end
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300 && oBusy; i++) @(negedge clock);
        chk(nm, 32'(oBusy), 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        iPlot = 1'b1; iX = 8'(x); iY = 7'(y); iColour = 9'(c);
    endtask

    task automatic pulse_clrflags();
        @(negedge clock); iClrFlags = 1'b1;
        @(negedge clock); iClrFlags = 1'b0;
    endtask

    initial begin
        iX = '0; iY = '0; iColour = '0; iPlot = 0; iClear = 0; iClearColour = '0;
        iClrFlags = 0; iRdReq = 0; iRdAddr = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_fb_wren", 32'(fb_wren), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_rdvalid", 32'(oRdValid), 0);
        chk("rst_dropcount", 32'(oDropCount), 0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Single plot: write two cycles later at 2*160+5
        @(negedge clock); set_plot(5, 2, 'h1FF);
        @(negedge clock); iPlot = 0;
        @(negedge clock);
        chk("t1_wren", 32'(fb_wren), 1);
        chk("t1_addr", 32'(fb_address), 325);
        chk("t1_data", 32'(fb_data), 'h1FF);
        wait_idle("t1_busy");

        // Ten plots while reads hog the port: eight buffered, overflow set
        pulse_clrflags();
        iRdReq = 1'b1; iRdAddr = 15'd77;
        for (int k = 0; k < 10; k++) begin
            set_plot(10 + k, 5, k);
            @(negedge clock);
        end
        iPlot = 0;
        chk("t2_overflow", 32'(oOverflow), 1);
        iRdReq = 1'b0;
        wa.delete(); wd.delete();
        collect(20);
        chk("t2_nwrites", 32'(wa.size()), 8);
        for (int i = 0; i < 8; i++)
            chk("t2_order", (i < wa.size()) ? 32'(wa[i]) : 32'hFFFF_FFFF, 32'(810 + i));
        wait_idle("t2_busy");

        // Out-of-range plots are counted; corner pixel written at 19199
        pulse_clrflags();
        @(negedge clock); set_plot(160, 0, 1);
        @(negedge clock); set_plot(0, 120, 2);
        @(negedge clock); set_plot(159, 119, 3);
        @(negedge clock); iPlot = 0;
        chk("t3_dropcount", 32'(oDropCount), 2);
        chk("t3_overflow", 32'(oOverflow), 0);
        wa.delete(); wd.delete();
        collect(10);
        chk("t3_nwrites", 32'(wa.size()), 1);
        chk("t3_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 19199);
        wait_idle("t3_busy");

        // Read of 1234 after it was plotted; queued plot waits one cycle
        @(negedge clock); set_plot(114, 7, 'h0AB);
        @(negedge clock); set_plot(1, 1, 'h155);
        @(negedge clock); iPlot = 0; iRdReq = 1'b1; iRdAddr = 15'd1234;
        chk("t4_first_write", 32'(fb_address), 1234);
        @(negedge clock); iRdReq = 1'b0;
        chk("t4_read_wren", 32'(fb_wren), 0);
        chk("t4_read_addr", 32'(fb_address), 1234);
        @(negedge clock);
        chk("t4_rdvalid", 32'(oRdValid), 1);
        chk("t4_rddata", 32'(oRdData), 'h0AB);
        chk("t4_queued_wren", 32'(fb_wren), 1);
        chk("t4_queued_addr", 32'(fb_address), 161);
        wait_idle("t4_busy");

        // Drop counter saturation and flag-clear priority
        pulse_clrflags();
        for (int k = 0; k < 300; k++) begin
            @(negedge clock); set_plot(200, k % 128, 0);
        end
        @(negedge clock); iPlot = 0;
        chk("t5_saturate", 32'(oDropCount), 255);
        set_plot(170, 0, 0); iClrFlags = 1'b1;
        @(negedge clock); iPlot = 0; iClrFlags = 1'b0;
        chk("t5_clr_priority", 32'(oDropCount), 0);

        // Full-screen clear with a plot and a stray iClear arriving mid-clear
        wait_idle("t6_pre_busy");
        iClear = 1'b1; iClearColour = 9'h007;
        cnt = 0; ndone = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clock);
            iClear = (i == 3000);
            iClearColour = (i == 3000) ? 9'h1FF : 9'h007;
            iPlot = (i == 5000); iX = '0; iY = '0; iColour = 9'h0F0;
            if (fb_wren) cnt++;
            if (oClearDone) begin ndone++; break; end
        end
        iClear = 0; iPlot = 0;
        wa.delete(); wd.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (oClearDone) ndone++;
            if (fb_wren) begin wa.push_back(fb_address); wd.push_back(fb_data); end
        end
        chk("t6_clear_writes", 32'(cnt), 19200);
        chk("t6_done_pulses", 32'(ndone), 1);
        chk("t6_post_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 0);
        chk("t6_post_data", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF_FFFF, 'h0F0);
        wait_idle("t6_busy");

        // Randomized traffic against the model
        rd_pct = 20;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (i % 500 == 0) rd_pct = (rd_pct == 20) ? 80 : 20;
            iPlot = ($urandom % 2) == 0;
            iX = ($urandom % 8 == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 15));
            iY = ($urandom % 8 == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 3));
            iColour = 9'($urandom);
            iRdReq = int'($urandom % 100) < rd_pct;
            iRdAddr = 15'($urandom % 600);
            iClrFlags = ($urandom % 32) == 0;
        end
        @(negedge clock); iPlot = 0; iRdReq = 0; iClrFlags = 0;
        wait_idle("t7_busy");

        // Reset in the middle of a clear with three plots queued
        iClear = 1'b1; iClearColour = 9'h1C0;
        @(negedge clock); iClear = 0; set_plot(3, 3, 1);
        @(negedge clock); set_plot(4, 3, 2);
        @(negedge clock); set_plot(5, 3, 3);
        @(negedge clock); iPlot = 0;
        repeat (100) @(negedge clock);
        chk("t8_pre_busy", 32'(oBusy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("t8_rst_wren", 32'(fb_wren), 0);
        chk("t8_rst_busy", 32'(oBusy), 0);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        cnt = 0; ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (fb_wren) cnt++;
            if (oClearDone) ndone++;
        end
        chk("t8_no_writes", 32'(cnt), 0);
        chk("t8_no_done", 32'(ndone), 0);
        chk("t8_busy", 32'(oBusy), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
